// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, types and helpers for the 3-digit scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int IDX_W      = 2;
  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = 3'b111;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  // Select digit nibble idx out of the packed 12-bit display value.
  function automatic logic [3:0] nibble_sel(input logic [4*NUM_DIGITS-1:0] v, input idx_t idx);
    logic [3:0] n;
    n = 4'h0;
    case (idx)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // Active-low enable pattern with only digit idx driven low.
  function automatic logic [NUM_DIGITS-1:0] digit_on_mask(input idx_t idx);
    logic [NUM_DIGITS-1:0] m;
    m = DIGIT_OFF;
    case (idx)
      2'd0:    m = 3'b110;
      2'd1:    m = 3'b101;
      2'd2:    m = 3'b011;
      default: m = DIGIT_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: slot counter and digit index for the display scan.
// cnt/idx name the cycle the controller presents at the next clock edge.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 12000,
  parameter int BLANK_CYCLES = 120,
  localparam int CW          = $clog2(SCAN_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt,
  output idx_t          idx,
  output logic          slot_start,
  output logic          blank_phase
);

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam idx_t          IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Slot counter wraps at SCAN_DIV and advances the digit index 0->1->2->0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Slot start and blanking window decode.
  always_comb begin
    slot_start  = (cnt == '0);
    blank_phase = (cnt < BLANK_END);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 3-digit 7-segment scan controller.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits 2 and 1.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 12000,
  parameter int BLANK_CYCLES = 120
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [4*NUM_DIGITS-1:0] VAL,
  input  logic                    LOAD,
  output logic [3:0]              DEC_D,
  output logic [NUM_DIGITS-1:0]   DIGIT,
  output logic                    FRAME_PULSE
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]           cnt;
  idx_t                    idx;
  logic                    slot_start;
  logic                    blank_phase;
  logic                    frame_start;
  scan_state_t             state;
  logic                    digit_en;
  logic [4*NUM_DIGITS-1:0] pend;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [4*NUM_DIGITS-1:0] disp_next;
  logic [NUM_DIGITS-1:0]   digit_nxt;
  logic [NUM_DIGITS-1:0]   digit_p1;
  logic [3:0]              dec_d_p1;
  logic                    frame_p1;

  seg_scan_timer #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk        (CLK),
    .rst_n      (RST_N),
    .cnt        (cnt),
    .idx        (idx),
    .slot_start (slot_start),
    .blank_phase(blank_phase)
  );

  // Frame boundary decode and displayed-value update (a coincident LOAD wins).
  always_comb begin
    frame_start = (cnt == '0) && (idx == '0);
    disp_next   = disp;
    if (frame_start) begin
      disp_next = LOAD ? VAL : pend;
    end
  end

  // Scan state and digit enable, with optional leading-zero suppression.
  always_comb begin
    state    = blank_phase ? BLANK : ON;
    digit_en = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx == 2'd2) && (disp[11:8] == 4'h0)) digit_en = 1'b0;
    if ((idx == 2'd1) && (disp[11:4] == 8'h00)) digit_en = 1'b0;
`endif
    digit_nxt = DIGIT_OFF;
    if ((state == ON) && digit_en) begin
      digit_nxt = digit_on_mask(idx);
    end
  end

  // Pending and displayed value registers; displayed only changes at frame start.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend <= '0;
      disp <= '0;
    end else begin
      if (LOAD) pend <= VAL;
      disp <= disp_next;
    end
  end

  // ---- stage p1: registered display pins ----
  // DIGIT/DEC_D/FRAME_PULSE registers; DEC_D latches once per slot during blanking.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      digit_p1 <= DIGIT_OFF;
      dec_d_p1 <= 4'h0;
      frame_p1 <= 1'b0;
    end else begin
      digit_p1 <= digit_nxt;
      frame_p1 <= frame_start;
      if (slot_start) dec_d_p1 <= nibble_sel(disp_next, idx);
    end
  end

  assign DIGIT       = digit_p1;
  assign DEC_D       = dec_d_p1;
  assign FRAME_PULSE = frame_p1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench with a frame-level reference model.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV     = 10;
  localparam int BLANK_CYCLES = 2;

  typedef struct packed {
    logic [2:0] digit;
    logic [3:0] dec;
    logic       fp;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        LOAD;
  logic [11:0] VAL;
  logic [3:0]  DEC_D;
  logic [2:0]  DIGIT;
  logic        FRAME_PULSE;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  exp_t        sb[$];
  int          m_k;
  logic [11:0] m_pend;
  logic [11:0] m_disp;
  logic [3:0]  m_dec;

  seg_scan_ctrl #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .VAL        (VAL),
    .LOAD       (LOAD),
    .DEC_D      (DEC_D),
    .DIGIT      (DIGIT),
    .FRAME_PULSE(FRAME_PULSE)
  );

  always #5 CLK = ~CLK;

  function automatic bit shown(input int id, input logic [11:0] d);
`ifdef LEADING_ZERO_BLANK_EN
    if (id == 2 && d[11:8] == 4'h0) return 1'b0;
    if (id == 1 && d[11:4] == 8'h00) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // Drive one cycle of inputs and queue what the display must show after that edge.
  task automatic step(input logic rst_n, input logic load, input logic [11:0] val);
    exp_t       e;
    int         pos;
    int         id;
    logic [2:0] one;
    @(negedge CLK);
    RST_N = rst_n;
    LOAD  = load;
    VAL   = val;
    if (!rst_n) begin
      m_k = 0; m_pend = '0; m_disp = '0; m_dec = '0;
      e.digit = 3'b111; e.dec = 4'h0; e.fp = 1'b0;
    end else begin
      pos = m_k % SCAN_DIV;
      id  = (m_k / SCAN_DIV) % 3;
      if (pos == 0 && id == 0) m_disp = load ? val : m_pend;
      if (load) m_pend = val;
      if (pos == 0) m_dec = m_disp[4*id +: 4];
      one     = 3'b001;
      e.fp    = (pos == 0 && id == 0);
      e.dec   = m_dec;
      e.digit = (pos >= BLANK_CYCLES && shown(id, m_disp)) ? ~(one << id) : 3'b111;
      m_k++;
    end
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        cyc++;
        chk("DIGIT", int'(DIGIT), int'(e.digit));
        chk("DEC_D", int'(DEC_D), int'(e.dec));
        chk("FRAME_PULSE", int'(FRAME_PULSE), int'(e.fp));
        chk("DIGIT_onehot", ($countones(~DIGIT) <= 1) ? 1 : 0, 1);
      end
    end
  end

  logic [11:0] v;
  logic        ld;

  initial begin
    RST_N = 1'b0; LOAD = 1'b0; VAL = '0;
    step(1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b0, 12'h000);

    // Directed frames: idle, mid-frame load, last-load-wins, boundary load, leading zeros.
    for (int t = 0; t < 300; t++) begin
      ld = 1'b0; v = 12'h000;
      case (t)
        5:   begin ld = 1'b1; v = 12'h3A5; end
        42:  begin ld = 1'b1; v = 12'h111; end
        55:  begin ld = 1'b1; v = 12'h222; end
        90:  begin ld = 1'b1; v = 12'h789; end
        125: begin ld = 1'b1; v = 12'h005; end
        185: begin ld = 1'b1; v = 12'h050; end
        245: begin ld = 1'b1; v = 12'h000; end
        default: ;
      endcase
      step(1'b1, ld, v);
    end

    // Mid-slot reset with a value loaded beforehand.
    for (int t = 0; t < 15; t++) step(1'b1, (t == 3), 12'h4B6);
    step(1'b0, 1'b0, 12'h000);
    for (int t = 0; t < 40; t++) step(1'b1, 1'b0, 12'h000);

    // Randomized loads, values biased toward zero nibbles, occasional resets.
    for (int t = 0; t < 3000; t++) begin
      ld = ($urandom_range(0, 7) == 0);
      for (int n = 0; n < 3; n++)
        v[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1, ld, v);
    end

    @(posedge CLK);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
